// File: rtl/bus_msg_issuer_pkg.sv
// Shared encodings for the coherence bus message issuer: bus message codes,
// CPU-side MSI line states and the issue FSM states.
package bus_msg_issuer_pkg;

  typedef enum logic [1:0] {
    MSG_READ_MISS  = 2'b00,
    MSG_WRITE_MISS = 2'b01,
    MSG_INVALIDATE = 2'b10,
    MSG_WRITE_BACK = 2'b11
  } bus_msg_e;

  typedef enum logic [1:0] {
    INVALID  = 2'b00,
    SHARED   = 2'b01,
    MODIFIED = 2'b10
  } cpu_state_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    ISSUE = 2'b10
  } issue_state_e;

endpackage

// File: rtl/bus_msg_issuer_fifo.sv
// Circular message FIFO with a dual write port so a write-back and its
// companion miss land in consecutive slots in one cycle.
module msg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push0,
  input  logic [WIDTH-1:0] push0_data,
  input  logic             push1,
  input  logic [WIDTH-1:0] push1_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    next_count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, wr_ptr_p1;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    n_push;
  logic             do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem[rd_ptr_q];
  assign count     = count_q;
  assign next_count = count_d;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    n_push    = '0;
    wr_ptr_p1 = wr_ptr_q + AW'(1);
    do_pop    = pop & ~empty;
    if (push0) n_push = (push1) ? CW'(2) : CW'(1);
    wr_ptr_d  = wr_ptr_q + AW'(n_push);
    rd_ptr_d  = rd_ptr_q + AW'(do_pop);
    count_d   = count_q + n_push - CW'(do_pop);
  end

  // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clock) begin
    if (push0)          mem[wr_ptr_q]  <= push0_data;
    if (push0 && push1) mem[wr_ptr_p1] <= push1_data;
  end

endmodule

// File: rtl/bus_msg_issuer.sv
// Encodes CPU-FSM command pulses into bus messages, queues them, and issues
// them on the snooping bus via req/grant, locking the bus after a write-back.
module bus_msg_issuer
  import bus_msg_issuer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              writeMiss,
  input  logic              readMiss,
  input  logic              writeBack,
  input  logic              invalidate,
  input  logic [ADDR_W-1:0] addr,
  input  logic              bus_grant,
  output logic              bus_req,
  output logic              bus_valid,
  output logic [1:0]        bus_msg,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              ready,
  output logic              overflow,
  output logic              protocol_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = 2 + ADDR_W;

  issue_state_e      state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_valid_q, bus_valid_d;
  bus_msg_e          bus_msg_q, bus_msg_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              ready_q, ready_d;
  logic              overflow_q, overflow_d;
  logic              protocol_err_q, protocol_err_d;

  logic              has_miss, fits, issue;
  bus_msg_e          miss_msg;
  logic              push0, push1, pop;
  logic [W-1:0]      push0_data, push1_data, head_data;
  logic [CW-1:0]     count, next_count;
  logic              full, empty;

  msg_fifo #(.DEPTH(DEPTH), .WIDTH(W)) u_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .push0      (push0),
    .push0_data (push0_data),
    .push1      (push1),
    .push1_data (push1_data),
    .pop        (pop),
    .head_data  (head_data),
    .count      (count),
    .next_count (next_count),
    .full       (full),
    .empty      (empty)
  );

  // Capacity is judged on start-of-cycle occupancy; a pair is all-or-nothing.
  always_comb begin
    has_miss = writeMiss | readMiss | invalidate;
    miss_msg = writeMiss ? MSG_WRITE_MISS : (readMiss ? MSG_READ_MISS : MSG_INVALIDATE);
    fits     = (writeBack && has_miss) ? (count <= CW'(DEPTH - 2)) : !full;
    push0      = (writeBack | has_miss) & fits;
    push0_data = writeBack ? {MSG_WRITE_BACK, addr} : {miss_msg, addr};
    push1      = writeBack & has_miss & fits;
    push1_data = {miss_msg, addr};
    overflow_d = overflow_q | ((writeBack | has_miss) & !fits);
    protocol_err_d = (writeMiss & readMiss) | (writeMiss & invalidate) | (readMiss & invalidate);
    ready_d    = (next_count <= CW'(DEPTH - 2));
  end

  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    bus_valid_d = 1'b0;
    bus_msg_d   = bus_msg_q;
    bus_addr_d  = bus_addr_q;
    pop         = 1'b0;
    case (state_q)
      IDLE:  if (!empty) state_d = REQ;
      REQ:   if (bus_grant && !empty) begin
               state_d = ISSUE;
               issue   = 1'b1;
             end
      // bus_msg_q is the message issued on the previous edge.
      ISSUE: if (bus_msg_q == MSG_WRITE_BACK && !empty) issue = 1'b1;
             else if (!empty) state_d = REQ;
             else             state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (issue) begin
      pop         = 1'b1;
      bus_valid_d = 1'b1;
      bus_msg_d   = bus_msg_e'(head_data[W-1 -: 2]);
      bus_addr_d  = head_data[ADDR_W-1:0];
    end
    bus_req_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      bus_req_q      <= 1'b0;
      bus_valid_q    <= 1'b0;
      bus_msg_q      <= MSG_READ_MISS;
      bus_addr_q     <= '0;
      ready_q        <= 1'b1;
      overflow_q     <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bus_req_q      <= bus_req_d;
      bus_valid_q    <= bus_valid_d;
      bus_msg_q      <= bus_msg_d;
      bus_addr_q     <= bus_addr_d;
      ready_q        <= ready_d;
      overflow_q     <= overflow_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_valid    = bus_valid_q;
  assign bus_msg      = bus_msg_q;
  assign bus_addr     = bus_addr_q;
  assign ready        = ready_q;
  assign overflow     = overflow_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_bus_msg_issuer.sv
// Directed self-checking bench for bus_msg_issuer: issue timing, write-back
// lock, capacity/overflow, protocol errors and asynchronous reset.
module tb_bus_msg_issuer;

  logic       clock;
  logic       resetn;
  logic       writeMiss, readMiss, writeBack, invalidate;
  logic [7:0] addr;
  logic       bus_grant;
  logic       bus_req, bus_valid;
  logic [1:0] bus_msg;
  logic [7:0] bus_addr;
  logic       ready, overflow, protocol_err;

  int n_checks = 0;
  int n_errors = 0;

  bus_msg_issuer #(.DEPTH(4), .ADDR_W(8)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .writeMiss    (writeMiss),
    .readMiss     (readMiss),
    .writeBack    (writeBack),
    .invalidate   (invalidate),
    .addr         (addr),
    .bus_grant    (bus_grant),
    .bus_req      (bus_req),
    .bus_valid    (bus_valid),
    .bus_msg      (bus_msg),
    .bus_addr     (bus_addr),
    .ready        (ready),
    .overflow     (overflow),
    .protocol_err (protocol_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic wm, input logic rm, input logic wb, input logic inv,
                       input logic [7:0] a);
    writeMiss = wm; readMiss = rm; writeBack = wb; invalidate = inv; addr = a;
    tick();
    writeMiss = 0; readMiss = 0; writeBack = 0; invalidate = 0;
  endtask

  task automatic do_reset();
    resetn = 0; bus_grant = 0;
    writeMiss = 0; readMiss = 0; writeBack = 0; invalidate = 0; addr = 0;
    tick(); tick();
    resetn = 1;
    tick();
  endtask

  task automatic wait_valid(input string tag, input logic [1:0] m, input logic [7:0] a);
    int n;
    n = 0;
    tick();
    while (!bus_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, bus_valid, 1);
    check({tag, "_msg"}, bus_msg, m);
    check({tag, "_addr"}, bus_addr, a);
  endtask

  initial begin
    int seen;
    do_reset();
    check("rst_req", bus_req, 0);
    check("rst_valid", bus_valid, 0);
    check("rst_msg", bus_msg, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_ready", ready, 1);
    check("rst_ovf", overflow, 0);
    check("rst_perr", protocol_err, 0);

    // Single read miss, grant tied high: req after edge 1, valid after edge 2 only.
    bus_grant = 1;
    pulse(0, 1, 0, 0, 8'h3A);
    check("rm_e0_req", bus_req, 0);
    tick();
    check("rm_e1_req", bus_req, 1);
    check("rm_e1_valid", bus_valid, 0);
    tick();
    check("rm_e2_valid", bus_valid, 1);
    check("rm_e2_msg", bus_msg, 2'b00);
    check("rm_e2_addr", bus_addr, 8'h3A);
    tick();
    check("rm_e3_req", bus_req, 0);
    check("rm_e3_valid", bus_valid, 0);
    check("rm_e3_hold_addr", bus_addr, 8'h3A);

    // Write-back + write miss: locked back-to-back issue despite grant dropping.
    bus_grant = 0;
    pulse(1, 0, 1, 0, 8'h11);
    tick();
    check("wb_req", bus_req, 1);
    bus_grant = 1;
    tick();
    bus_grant = 0;
    check("wb_valid", bus_valid, 1);
    check("wb_msg", bus_msg, 2'b11);
    check("wb_addr", bus_addr, 8'h11);
    tick();
    check("wb_lock_valid", bus_valid, 1);
    check("wb_lock_msg", bus_msg, 2'b01);
    check("wb_lock_addr", bus_addr, 8'h11);
    tick();
    check("wb_end_valid", bus_valid, 0);
    check("wb_end_req", bus_req, 0);

    // Fill to 4 with grant low, fifth is dropped, then drain in order.
    do_reset();
    pulse(0, 1, 0, 0, 8'h00);
    check("fill1_ready", ready, 1);
    pulse(0, 1, 0, 0, 8'h01);
    check("fill2_ready", ready, 1);
    pulse(0, 1, 0, 0, 8'h02);
    check("fill3_ready", ready, 0);
    pulse(0, 1, 0, 0, 8'h03);
    check("fill4_ovf", overflow, 0);
    pulse(0, 1, 0, 0, 8'h04);
    check("fill5_ovf", overflow, 1);
    check("fill5_req", bus_req, 1);
    bus_grant = 1;
    for (int i = 0; i < 4; i++) wait_valid($sformatf("drain%0d", i), 2'b00, 8'(i));
    tick();
    check("drain_idle_req", bus_req, 0);
    check("drain_ready", ready, 1);
    check("drain_ovf_sticky", overflow, 1);

    // Occupancy 3 plus a write-back pair: nothing enqueued.
    do_reset();
    bus_grant = 0;
    pulse(0, 1, 0, 0, 8'h20);
    pulse(0, 1, 0, 0, 8'h21);
    pulse(0, 1, 0, 0, 8'h22);
    check("pair_pre_ovf", overflow, 0);
    pulse(0, 1, 1, 0, 8'h77);
    check("pair_ovf", overflow, 1);
    check("pair_ready", ready, 0);
    check("pair_perr", protocol_err, 0);
    bus_grant = 1;
    wait_valid("pair_d0", 2'b00, 8'h20);
    wait_valid("pair_d1", 2'b00, 8'h21);
    wait_valid("pair_d2", 2'b00, 8'h22);
    tick();
    check("pair_idle_req", bus_req, 0);
    check("pair_idle_valid", bus_valid, 0);

    // Write miss + invalidate: one-cycle protocol error, only the write miss issued.
    do_reset();
    pulse(1, 0, 0, 1, 8'h55);
    check("perr_pulse", protocol_err, 1);
    tick();
    check("perr_clear", protocol_err, 0);
    bus_grant = 1;
    wait_valid("perr_issue", 2'b01, 8'h55);
    tick();
    check("perr_only_one_valid", bus_valid, 0);
    check("perr_only_one_req", bus_req, 0);

    // Asynchronous reset while issuing with 2 entries still queued.
    do_reset();
    pulse(0, 1, 0, 0, 8'h30);
    pulse(0, 1, 0, 0, 8'h31);
    pulse(0, 1, 0, 0, 8'h32);
    pulse(0, 1, 1, 0, 8'h99);
    check("ar_pre_ovf", overflow, 1);
    bus_grant = 1;
    wait_valid("ar_first", 2'b00, 8'h30);
    #2 resetn = 0;
    #1;
    check("ar_req", bus_req, 0);
    check("ar_valid", bus_valid, 0);
    check("ar_ovf", overflow, 0);
    check("ar_ready", ready, 1);
    tick();
    resetn = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus_valid || bus_req) seen++;
    end
    check("ar_quiet", seen, 0);
    pulse(0, 1, 0, 0, 8'h44);
    wait_valid("ar_new", 2'b00, 8'h44);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_msg_issuer.md
Name: bus_msg_issuer

Overview:
- Downstream of the CPU-side MSI coherence FSM; consumes its one-cycle command pulses (writeMiss, readMiss, writeBack, invalidate).
- Encodes each pulse as a bus message and buffers it in a small FIFO.
- Issues messages onto the shared snooping bus through a req/grant handshake.
- A write-back and its companion miss issue back-to-back, with the bus held locked between them.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 8, block address width carried with each message.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- writeMiss  in  1  CPU-FSM pulse: write miss.
- readMiss  in  1  CPU-FSM pulse: read miss.
- writeBack  in  1  CPU-FSM pulse: dirty block write-back.
- invalidate  in  1  CPU-FSM pulse: invalidate request.
- addr  in  ADDR_W  block address, valid with the pulses.
- bus_grant  in  1  arbiter grant.
- bus_req  out  1  bus request.
- bus_valid  out  1  message valid on the bus this cycle.
- bus_msg  out  2  00 READ_MISS, 01 WRITE_MISS, 10 INVALIDATE, 11 WRITE_BACK.
- bus_addr  out  ADDR_W  message address.
- ready  out  1  at least 2 free FIFO slots.
- overflow  out  1  sticky: messages were dropped.
- protocol_err  out  1  one-cycle pulse: illegal input combination.

Behaviour:
- Reset (async assert, sync release): FIFO emptied, FSM to IDLE, all outputs 0 except ready=1, overflow cleared. Reset mid-issue aborts silently; no partial message remains.
- Registered outputs: all outputs are registered.
- Enqueue, sampled each rising edge:
  - If writeBack=1, WRITE_BACK(addr) is pushed first.
  - Then at most one of WRITE_MISS, READ_MISS or INVALIDATE is pushed, with priority writeMiss > readMiss > invalidate.
  - Two or more of {writeMiss, readMiss, invalidate} high: protocol_err=1 next cycle; only the winner is enqueued.
  - writeBack alone (no miss): legal, a single push.
- Capacity:
  - The check uses the occupancy at the start of the cycle; a same-cycle pop gives no credit.
  - If the required slots (1 or 2) are not free, none of that cycle's messages are enqueued and overflow is set (sticky until reset).
  - A write-back is never split from its miss.
- Push and pop in the same cycle are legal; occupancy updates by the net change.
- FIFO: circular, pointers wrap modulo DEPTH. Occupancy counter is ceil(log2(DEPTH))+1 bits wide.
- Issue FSM, states IDLE, REQ, ISSUE:
  - IDLE: bus_req=0. At an edge with occupancy>0, go to REQ and set bus_req=1. A message enqueued at edge N raises bus_req at edge N+1; there is no bypass.
  - REQ: bus_req=1. At an edge with bus_grant=1, go to ISSUE. The same edge loads bus_valid=1, bus_msg/bus_addr=head, and pops the head.
  - ISSUE (one message per cycle):
    - If the message just issued was WRITE_BACK and the FIFO is non-empty: stay in ISSUE and issue the next head at the next edge regardless of bus_grant (lock).
    - Otherwise, if the FIFO is non-empty: go to REQ (bus_req stays 1, bus_valid=0).
    - Otherwise: go to IDLE (bus_req=0, bus_valid=0).
- bus_valid is high for exactly one cycle per message. bus_msg and bus_addr hold their last value when bus_valid=0.
- Grant dropping while in REQ: keep waiting.
- Grant arriving while in IDLE: ignored.

Decomposition:
- Shared package holds:
  - Message encodings MSG_READ_MISS, MSG_WRITE_MISS, MSG_INVALIDATE, MSG_WRITE_BACK.
  - CPU-side state encodings: INVALID 00, SHARED 01, MODIFIED 10.
  - Issue FSM state encodings.
- One sub-module: msg_fifo (DEPTH x (2+ADDR_W)), with push0/push1 dual-write, pop, count, full/empty. The top level holds the encoder and the issue FSM.

Test Plan:
- readMiss=1, addr=0x3A at edge 0; bus_grant tied to 1 -> bus_req=1 after edge 1; bus_valid=1 with msg=00, addr=0x3A after edge 2 only; bus_req=0 after edge 3.
- writeMiss=1 and writeBack=1, addr=0x11; grant high for one cycle at the REQ edge then low -> WRITE_BACK(0x11) then WRITE_MISS(0x11) on consecutive cycles with no gap, despite grant dropping.
- Fill FIFO with 4 single messages while grant=0, then pulse readMiss -> ready=0 once occupancy is 3; the 5th message is dropped; overflow=1 stays set; the queued 4 drain in order 0..3 when grant=1.
- Occupancy 3 (1 free) plus writeBack+readMiss in the same cycle -> neither is enqueued; overflow=1; occupancy stays 3.
- writeMiss=1 and invalidate=1 together, addr=0x55 -> protocol_err pulses for 1 cycle; only WRITE_MISS(0x55) is issued.
- resetn low while in ISSUE holding 2 entries -> bus_req, bus_valid and overflow go 0 immediately (async); nothing issues after release until a new pulse arrives.
